// File: rtl/vanilla_trace_buffer.sv
// ---------------------------------------------------------------------------
// vanilla_trace_buffer
//
// Purpose:
//   Trace capture buffer for one vanilla core, placed right after the
//   writeback stage. Every cycle it turns retire and register-file write
//   events into fixed 142-bit records and pushes them into a small circular
//   FIFO. The FIFO drains to a trace sink over a valid/ready handshake.
//   Records that cannot be stored are counted in a saturating drop counter.
//
// Record layout (MSB..LSB, 142 bits):
//   kind[1:0] (00 retire, 01 writeback-only, 10 stall-run), pc[31:0],
//   instr[31:0], int_v, int_addr[4:0], int_data[31:0],
//   fp_v, fp_addr[4:0], fp_data[31:0]
//
// Optional feature macro: VANILLA_TRACE_STALL_RECORD_EN
//   When defined, runs of consecutive stall cycles are counted. Each run
//   emits a kind-10 record when it closes: pc holds the run length and
//   instr holds the OR of the stall reasons seen during the run. One cycle
//   can then enqueue two records, the stall-run record first and the event
//   record second. When the macro is undefined, stall cycles produce no
//   records and at most one record is enqueued per cycle.
//
// Ports:
//   clk_i, reset_i          core clock, asynchronous active-high reset
//   trace_en_i              capture enable (also closes/discards a stall run)
//   stall_all_i             core pipeline stall
//   stall_reason_i[2:0]     {ifetch, loadwb, flw_wb}
//   retire_v_i/pc/instr     writeback-stage instruction
//   int_rf_*/float_rf_*     integer / FP register-file write ports
//   trace_v_o, trace_data_o FIFO head (valid, record)
//   trace_ready_i           sink accepts the head when high with trace_v_o
//   drop_count_o            saturating count of dropped records
//   occupancy_o             records currently held
// ---------------------------------------------------------------------------
module vanilla_trace_buffer #(
    parameter int els_p            = 8,
    parameter int drop_cnt_width_p = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        trace_en_i,
    input  logic                        stall_all_i,
    input  logic [2:0]                  stall_reason_i,
    input  logic                        retire_v_i,
    input  logic [31:0]                 retire_pc_i,
    input  logic [31:0]                 retire_instr_i,
    input  logic                        int_rf_wen_i,
    input  logic [4:0]                  int_rf_waddr_i,
    input  logic [31:0]                 int_rf_wdata_i,
    input  logic                        float_rf_wen_i,
    input  logic [4:0]                  float_rf_waddr_i,
    input  logic [31:0]                 float_rf_wdata_i,
    output logic                        trace_v_o,
    output logic [141:0]                trace_data_o,
    input  logic                        trace_ready_i,
    output logic [drop_cnt_width_p-1:0] drop_count_o,
    output logic [$clog2(els_p):0]      occupancy_o
);

    localparam int AW = $clog2(els_p);
    localparam int PW = AW + 1;
    localparam int RW = 142;
    localparam int DW = drop_cnt_width_p;
    localparam logic [PW:0] DEPTH = (PW + 1)'(els_p);

    // Builds one register-file field; inactive writes are all-zero.
    function automatic logic [37:0] rf_field(input logic v, input logic [4:0] a,
                                             input logic [31:0] d);
        if (v) begin
            rf_field = {1'b1, a, d};
        end else begin
            rf_field = 38'd0;
        end
    endfunction

    // Storage and pointers. The extra pointer MSB separates full from empty.
    logic [RW-1:0]  r_mem [els_p];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [DW-1:0]  r_drop;

    logic [PW-1:0]  w_occ;
    logic           w_deq;
    logic           w_ret;
    logic           w_wbo;
    logic           w_req_a;
    logic           w_req_b;
    logic [RW-1:0]  w_rec_a;
    logic [RW-1:0]  w_rec_b;
    logic [PW:0]    w_avail;
    logic           w_acc_a;
    logic           w_acc_b;
    logic [1:0]     w_ndrop;
    logic [AW-1:0]  w_waddr_a;
    logic [AW-1:0]  w_waddr_b;
    logic [DW:0]    w_drop_sum;
    logic [DW-1:0]  w_drop_nxt;

    assign w_occ        = r_wptr - r_rptr;
    assign trace_v_o    = (w_occ != {PW{1'b0}});
    assign trace_data_o = r_mem[r_rptr[AW-1:0]];
    assign occupancy_o  = w_occ;
    assign drop_count_o = r_drop;
    assign w_deq        = trace_v_o & trace_ready_i;

    // Classifies this cycle's event and builds the retire/writeback-only record.
    always_comb begin
        w_ret   = trace_en_i & ~stall_all_i & retire_v_i;
        w_wbo   = trace_en_i & ~w_ret & (int_rf_wen_i | float_rf_wen_i);
        w_req_b = w_ret | w_wbo;
        if (w_ret) begin
            w_rec_b = {2'b00, retire_pc_i, retire_instr_i,
                       rf_field(int_rf_wen_i, int_rf_waddr_i, int_rf_wdata_i),
                       rf_field(float_rf_wen_i, float_rf_waddr_i, float_rf_wdata_i)};
        end else begin
            w_rec_b = {2'b01, 64'd0,
                       rf_field(int_rf_wen_i, int_rf_waddr_i, int_rf_wdata_i),
                       rf_field(float_rf_wen_i, float_rf_waddr_i, float_rf_wdata_i)};
        end
    end

`ifdef VANILLA_TRACE_STALL_RECORD_EN
    logic [15:0] r_stall_cnt;
    logic [2:0]  r_stall_rsn;

    // A run is open whenever the counter is non-zero; it closes on the first
    // unstalled cycle or on a writeback-only event (that cycle is not counted).
    assign w_req_a = trace_en_i & (r_stall_cnt != 16'd0) & (~stall_all_i | w_wbo);
    assign w_rec_a = {2'b10, 16'd0, r_stall_cnt, 29'd0, r_stall_rsn, 76'd0};

    // Stall-run length and accumulated reasons; cleared when capture is off.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stall_cnt <= 16'd0;
            r_stall_rsn <= 3'd0;
        end else if (trace_en_i & stall_all_i & ~w_wbo) begin
            if (r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            r_stall_rsn <= r_stall_rsn | stall_reason_i;
        end else begin
            r_stall_cnt <= 16'd0;
            r_stall_rsn <= 3'd0;
        end
    end
`else
    logic w_unused_stall_reason;

    assign w_req_a               = 1'b0;
    assign w_rec_a               = {RW{1'b0}};
    assign w_unused_stall_reason = ^stall_reason_i;
`endif

    // Admission: slots freed by a same-cycle dequeue are usable; the stall-run
    // record has priority, and anything that does not fit is counted.
    always_comb begin
        w_avail   = DEPTH - {1'b0, w_occ} + (PW + 1)'(w_deq);
        w_acc_a   = w_req_a & (w_avail != {(PW + 1){1'b0}});
        w_acc_b   = w_req_b & (w_avail > (PW + 1)'(w_acc_a));
        w_ndrop   = {1'b0, w_req_a & ~w_acc_a} + {1'b0, w_req_b & ~w_acc_b};
        w_waddr_a = r_wptr[AW-1:0];
        w_waddr_b = r_wptr[AW-1:0] + AW'(w_acc_a);
        w_drop_sum = {1'b0, r_drop} + (DW + 1)'(w_ndrop);
        if (w_drop_sum[DW]) begin
            w_drop_nxt = {DW{1'b1}};
        end else begin
            w_drop_nxt = w_drop_sum[DW-1:0];
        end
    end

    // Pointer and drop-counter update.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr <= {PW{1'b0}};
            r_rptr <= {PW{1'b0}};
            r_drop <= {DW{1'b0}};
        end else begin
            r_wptr <= r_wptr + PW'(w_acc_a) + PW'(w_acc_b);
            r_rptr <= r_rptr + PW'(w_deq);
            r_drop <= w_drop_nxt;
        end
    end

    // Record storage; writes only ever land in free slots or the slot being
    // dequeued this cycle, so the presented head never changes under backpressure.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                r_mem[i] <= {RW{1'b0}};
            end
        end else begin
            if (w_acc_a) begin
                r_mem[w_waddr_a] <= w_rec_a;
            end
            if (w_acc_b) begin
                r_mem[w_waddr_b] <= w_rec_b;
            end
        end
    end

endmodule

// File: tb/tb_vanilla_trace_buffer.sv
module tb_vanilla_trace_buffer;

    localparam int EL  = 8;
    localparam int DW  = 4;
    localparam int RW  = 142;
    localparam int MAXD = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          trace_en_i;
    logic          stall_all_i;
    logic [2:0]    stall_reason_i;
    logic          retire_v_i;
    logic [31:0]   retire_pc_i;
    logic [31:0]   retire_instr_i;
    logic          int_rf_wen_i;
    logic [4:0]    int_rf_waddr_i;
    logic [31:0]   int_rf_wdata_i;
    logic          float_rf_wen_i;
    logic [4:0]    float_rf_waddr_i;
    logic [31:0]   float_rf_wdata_i;
    logic          trace_v_o;
    logic [RW-1:0] trace_data_o;
    logic          trace_ready_i;
    logic [DW-1:0] drop_count_o;
    logic [3:0]    occupancy_o;

    vanilla_trace_buffer #(.els_p(EL), .drop_cnt_width_p(DW)) dut (
        .clk_i(clk), .reset_i(reset_i), .trace_en_i(trace_en_i),
        .stall_all_i(stall_all_i), .stall_reason_i(stall_reason_i),
        .retire_v_i(retire_v_i), .retire_pc_i(retire_pc_i),
        .retire_instr_i(retire_instr_i), .int_rf_wen_i(int_rf_wen_i),
        .int_rf_waddr_i(int_rf_waddr_i), .int_rf_wdata_i(int_rf_wdata_i),
        .float_rf_wen_i(float_rf_wen_i), .float_rf_waddr_i(float_rf_waddr_i),
        .float_rf_wdata_i(float_rf_wdata_i), .trace_v_o(trace_v_o),
        .trace_data_o(trace_data_o), .trace_ready_i(trace_ready_i),
        .drop_count_o(drop_count_o), .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of records, a drop tally, an open stall run.
    logic [RW-1:0] q[$];
    int            m_drops = 0;
    int            m_scnt  = 0;
    logic [2:0]    m_rsn   = 3'd0;

    function automatic logic [RW-1:0] mkrec(input logic [1:0] k, input logic [31:0] pc,
        input logic [31:0] ins, input logic iv, input logic [4:0] ia, input logic [31:0] id,
        input logic fv, input logic [4:0] fa, input logic [31:0] fd);
        if (!iv) begin ia = 5'd0; id = 32'd0; end
        if (!fv) begin fa = 5'd0; fd = 32'd0; end
        return {k, pc, ins, iv, ia, id, fv, fa, fd};
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Applies the capture/FIFO rules for the edge that just happened.
    task automatic model_edge();
        logic [RW-1:0] recs[$];
        bit deq, ret, wbo;
        deq = (q.size() > 0) && trace_ready_i;
        ret = trace_en_i && !stall_all_i && retire_v_i;
        wbo = trace_en_i && !ret && (int_rf_wen_i || float_rf_wen_i);
`ifdef VANILLA_TRACE_STALL_RECORD_EN
        if (trace_en_i && m_scnt > 0 && (!stall_all_i || wbo))
            recs.push_back(mkrec(2'b10, 32'(m_scnt), {29'd0, m_rsn}, 1'b0, 5'd0, 32'd0,
                                 1'b0, 5'd0, 32'd0));
        if (!trace_en_i || !stall_all_i || wbo) begin
            m_scnt = 0;
            m_rsn  = 3'd0;
        end else begin
            if (m_scnt < 65535) m_scnt++;
            m_rsn = m_rsn | stall_reason_i;
        end
`endif
        if (ret)
            recs.push_back(mkrec(2'b00, retire_pc_i, retire_instr_i, int_rf_wen_i,
                int_rf_waddr_i, int_rf_wdata_i, float_rf_wen_i, float_rf_waddr_i,
                float_rf_wdata_i));
        else if (wbo)
            recs.push_back(mkrec(2'b01, 32'd0, 32'd0, int_rf_wen_i, int_rf_waddr_i,
                int_rf_wdata_i, float_rf_wen_i, float_rf_waddr_i, float_rf_wdata_i));
        if (deq) void'(q.pop_front());
        foreach (recs[i]) begin
            if (q.size() < EL) q.push_back(recs[i]);
            else if (m_drops < MAXD) m_drops++;
        end
    endtask

    task automatic check_all();
        chk("valid", RW'(trace_v_o), RW'(q.size() > 0));
        chk("occupancy", RW'(occupancy_o), RW'(q.size()));
        chk("drops", RW'(drop_count_o), RW'(m_drops));
        if (q.size() > 0) chk("head", trace_data_o, q[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        stall_all_i = 1'b0; stall_reason_i = 3'd0; retire_v_i = 1'b0;
        retire_pc_i = 32'd0; retire_instr_i = 32'd0;
        int_rf_wen_i = 1'b0; int_rf_waddr_i = 5'd0; int_rf_wdata_i = 32'd0;
        float_rf_wen_i = 1'b0; float_rf_waddr_i = 5'd0; float_rf_wdata_i = 32'd0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] ins);
        idle();
        retire_v_i = 1'b1; retire_pc_i = pc; retire_instr_i = ins;
    endtask

    initial begin
        reset_i = 1'b1; trace_en_i = 1'b0; trace_ready_i = 1'b0;
        idle();
        #3;
        chk("rst_valid", RW'(trace_v_o), RW'(0));
        chk("rst_data", trace_data_o, {RW{1'b0}});
        chk("rst_occ", RW'(occupancy_o), RW'(0));
        chk("rst_drop", RW'(drop_count_o), RW'(0));
        #9 reset_i = 1'b0;

        // Single retire with an integer write.
        trace_en_i = 1'b1; trace_ready_i = 1'b1;
        retire(32'h1000, 32'h0050_0093);
        int_rf_wen_i = 1'b1; int_rf_waddr_i = 5'd1; int_rf_wdata_i = 32'd5;
        tick();
        chk("t1_kind", RW'(trace_data_o[141:140]), RW'(2'b00));
        chk("t1_pc", RW'(trace_data_o[139:108]), RW'(32'h1000));
        chk("t1_instr", RW'(trace_data_o[107:76]), RW'(32'h0050_0093));
        chk("t1_int", RW'(trace_data_o[75:38]), RW'({1'b1, 5'd1, 32'd5}));
        chk("t1_fpv", RW'(trace_data_o[37]), RW'(0));
        idle();
        tick();

        // Overfill with the sink stalled.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            retire(32'h2000 + 32'(4 * i), 32'(i));
            tick();
        end
        chk("full_occ", RW'(occupancy_o), RW'(8));
        chk("full_drop", RW'(drop_count_o), RW'(2));

        // Full FIFO, retire with simultaneous dequeue.
        trace_ready_i = 1'b1;
        retire(32'h3000, 32'h1);
        tick();
        chk("fulldq_occ", RW'(occupancy_o), RW'(8));
        chk("fulldq_drop", RW'(drop_count_o), RW'(2));
        chk("fulldq_head", RW'(trace_data_o[139:108]), RW'(32'h2004));
        idle();
        for (int i = 0; i < 9; i++) tick();

`ifdef VANILLA_TRACE_STALL_RECORD_EN
        // Stall run closed by a retire.
        trace_ready_i = 1'b0;
        idle(); stall_all_i = 1'b1; stall_reason_i = 3'b010;
        for (int i = 0; i < 5; i++) tick();
        retire(32'h4000, 32'h13);
        tick();
        chk("srun_occ", RW'(occupancy_o), RW'(2));
        chk("srun_kind", RW'(trace_data_o[141:140]), RW'(2'b10));
        chk("srun_pc", RW'(trace_data_o[139:108]), RW'(5));
        chk("srun_instr", RW'(trace_data_o[107:76]), RW'(3'b010));
        idle(); trace_ready_i = 1'b1;
        tick();
        chk("srun_next", RW'(trace_data_o[141:140]), RW'(2'b00));
        tick();

        // Stall run split by a writeback-only event.
        trace_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            idle(); stall_all_i = 1'b1;
            if (i == 3) begin
                int_rf_wen_i = 1'b1; int_rf_waddr_i = 5'd3; int_rf_wdata_i = 32'hdeadbeef;
            end
            tick();
        end
        idle();
        tick();
        chk("split_occ", RW'(occupancy_o), RW'(3));
        chk("split_a", RW'(trace_data_o[141:108]), RW'({2'b10, 32'd2}));
        trace_ready_i = 1'b1;
        tick();
        chk("split_b", RW'(trace_data_o[141:140]), RW'(2'b01));
        chk("split_bd", RW'(trace_data_o[69:38]), RW'(32'hdeadbeef));
        tick();
        chk("split_c", RW'(trace_data_o[141:108]), RW'({2'b10, 32'd3}));
        tick();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            trace_en_i       = ($urandom_range(0, 9) != 0);
            stall_all_i      = ($urandom_range(0, 2) == 0);
            stall_reason_i   = 3'($urandom);
            retire_v_i       = $urandom_range(0, 3) != 0;
            retire_pc_i      = $urandom;
            retire_instr_i   = $urandom;
            int_rf_wen_i     = ($urandom_range(0, 2) == 0);
            int_rf_waddr_i   = 5'($urandom);
            int_rf_wdata_i   = $urandom;
            float_rf_wen_i   = ($urandom_range(0, 3) == 0);
            float_rf_waddr_i = 5'($urandom);
            float_rf_wdata_i = $urandom;
            trace_ready_i    = $urandom_range(0, 1) != 0;
            tick();
        end

        // Asynchronous reset with records queued.
        trace_en_i = 1'b1; trace_ready_i = 1'b1; idle();
        for (int i = 0; i < EL + 2; i++) tick();
        trace_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            retire(32'h5000 + 32'(4 * i), 32'h7);
            tick();
        end
        chk("pre_rst_occ", RW'(occupancy_o), RW'(4));
        idle();
        #2 reset_i = 1'b1;
        #1;
        chk("arst_valid", RW'(trace_v_o), RW'(0));
        chk("arst_occ", RW'(occupancy_o), RW'(0));
        chk("arst_drop", RW'(drop_count_o), RW'(0));
        chk("arst_data", trace_data_o, {RW{1'b0}});
        q.delete(); m_drops = 0; m_scnt = 0; m_rsn = 3'd0;
        #2 reset_i = 1'b0;
        retire(32'h6000, 32'h9);
        tick();
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
